// File: rtl/taxi_eth_gmii_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : taxi_eth_gmii_tx_pkg
//  Purpose  : Shared types, constants and the CRC-32 step function for the
//             GMII frame transmitter.
//  Contents : tx_state_t  - transmitter state encoding
//             ETH_PRE / ETH_SFD - preamble and start-of-frame delimiter
//             CRC_POLY / CRC_INIT - reflected Ethernet CRC-32 parameters
//             crc32_byte() - advance the CRC register by one data byte
//  Revision : 1.0 - initial release
// ============================================================================
package taxi_eth_gmii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    PAD      = 3'd3,
    FCS      = 3'd4,
    DISCARD  = 3'd5,
    IFG      = 3'd6
  } tx_state_t;

  localparam logic [7:0]  ETH_PRE  = 8'h55;
  localparam logic [7:0]  ETH_SFD  = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Bit-serial reflected CRC-32, unrolled over one byte (LSB first).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/taxi_eth_gmii_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : taxi_eth_gmii_frame_tx
//  Purpose  : Single-clock GMII frame transmitter. Turns an 8-bit AXI-stream
//             frame into preamble/SFD, payload, optional zero pad, FCS and
//             inter-frame gap on a registered GMII interface.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             s_axis_tx_*           - 8-bit frame input (tuser[0] on tlast
//                                     marks a bad frame)
//             gmii_txd/tx_en/tx_er  - registered GMII transmit outputs
//             clk_enable            - advance qualifier, everything holds low
//             cfg_ifg               - inter-frame gap in bytes (0 acts as 1)
//             cfg_tx_enable         - permit the start of a new frame
//             tx_start_packet       - pulse with the first preamble byte
//             tx_error_underflow    - pulse with the underflow error byte
//             tx_frame_len          - payload+pad+FCS length of last frame
//             tx_frame_done         - pulse with the last FCS byte
//  Revision : 1.0 - initial release
// ============================================================================
module taxi_eth_gmii_frame_tx
  import taxi_eth_gmii_tx_pkg::*;
#(
  parameter logic PADDING_EN    = 1'b1,
  parameter int   MIN_FRAME_LEN = 64,
  parameter int   CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [7:0]       s_axis_tx_tdata,
  input  logic             s_axis_tx_tvalid,
  output logic             s_axis_tx_tready,
  input  logic             s_axis_tx_tlast,
  input  logic [0:0]       s_axis_tx_tuser,

  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,

  input  logic             clk_enable,
  input  logic [7:0]       cfg_ifg,
  input  logic             cfg_tx_enable,

  output logic             tx_start_packet,
  output logic             tx_error_underflow,
  output logic [CNT_W-1:0] tx_frame_len,
  output logic             tx_frame_done
);

  // Byte count (without FCS) at which padding stops.
  localparam logic [CNT_W-1:0] c_pad_len = CNT_W'(MIN_FRAME_LEN - 4);

  tx_state_t        state_q, state_d;
  logic [2:0]       idx_q, idx_d;       // preamble byte / FCS byte index
  logic [7:0]       ifg_q, ifg_d;       // remaining gap bytes
  logic [CNT_W-1:0] cnt_q, cnt_d;       // frame bytes sent (payload + pad)
  logic [31:0]      crc_q, crc_d;
  logic             bad_q, bad_d;
  logic [7:0]       txd_q, txd_d;
  logic             en_q, en_d;
  logic             er_q, er_d;
  logic             start_q, start_d;
  logic             uf_q, uf_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W:0]   w_len_sum;
  logic [CNT_W-1:0] w_len_fcs;
  logic [7:0]       w_ifg_load;
  logic [31:0]      w_fcs;
  logic [7:0]       w_fcs_byte;
  logic [31:0]      w_crc_data;
  logic [31:0]      w_crc_zero;

  assign w_cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign w_len_sum  = {1'b0, cnt_q} + (CNT_W+1)'(4);
  assign w_len_fcs  = w_len_sum[CNT_W] ? {CNT_W{1'b1}} : w_len_sum[CNT_W-1:0];
  assign w_ifg_load = (cfg_ifg == 8'd0) ? 8'd1 : cfg_ifg;
  assign w_fcs      = ~crc_q;
  assign w_crc_data = crc32_byte(crc_q, s_axis_tx_tdata);
  assign w_crc_zero = crc32_byte(crc_q, 8'h00);

  always_comb begin
    w_fcs_byte = w_fcs[7:0];
    case (idx_q[1:0])
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  // Ready is a combinational decode so that a stalled clk_enable never lets
  // a beat be accepted without the state advancing.
  assign s_axis_tx_tready = clk_enable &&
                            ((state_q == PAYLOAD) || (state_q == DISCARD));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ifg_d   = ifg_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    bad_d   = bad_q;
    txd_d   = txd_q;
    en_d    = en_q;
    er_d    = er_q;
    start_d = start_q;
    uf_d    = uf_q;
    done_d  = done_q;
    len_d   = len_q;

    if (clk_enable) begin
      txd_d   = 8'h00;
      en_d    = 1'b0;
      er_d    = 1'b0;
      start_d = 1'b0;
      uf_d    = 1'b0;
      done_d  = 1'b0;

      case (state_q)
        IDLE: begin
          // The first preamble byte is issued on the start decision itself
          // so the gap after IFG is exactly the programmed length.
          if (s_axis_tx_tvalid && cfg_tx_enable) begin
            txd_d   = ETH_PRE;
            en_d    = 1'b1;
            start_d = 1'b1;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
            bad_d   = 1'b0;
            idx_d   = 3'd1;
            state_d = PREAMBLE;
          end
        end

        PREAMBLE: begin
          en_d  = 1'b1;
          txd_d = (idx_q == 3'd7) ? ETH_SFD : ETH_PRE;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (s_axis_tx_tvalid) begin
            txd_d = s_axis_tx_tdata;
            en_d  = 1'b1;
            crc_d = w_crc_data;
            cnt_d = w_cnt_inc;
            if (s_axis_tx_tlast) begin
              bad_d   = s_axis_tx_tuser[0];
              idx_d   = 3'd0;
              state_d = (PADDING_EN && (w_cnt_inc < c_pad_len)) ? PAD : FCS;
            end
          end else begin
            // Source ran dry mid-frame: poison the frame on the wire.
            txd_d   = 8'h00;
            en_d    = 1'b1;
            er_d    = 1'b1;
            uf_d    = 1'b1;
            state_d = DISCARD;
          end
        end

        PAD: begin
          txd_d = 8'h00;
          en_d  = 1'b1;
          crc_d = w_crc_zero;
          cnt_d = w_cnt_inc;
          if (w_cnt_inc >= c_pad_len) begin
            idx_d   = 3'd0;
            state_d = FCS;
          end
        end

        FCS: begin
          txd_d = w_fcs_byte;
          en_d  = 1'b1;
          er_d  = bad_q;
          idx_d = idx_q + 3'd1;
          if (idx_q[1:0] == 2'd3) begin
            done_d  = 1'b1;
            len_d   = w_len_fcs;
            ifg_d   = w_ifg_load;
            state_d = IFG;
          end
        end

        DISCARD: begin
          if (s_axis_tx_tvalid && s_axis_tx_tlast) begin
            ifg_d   = w_ifg_load;
            state_d = IFG;
          end
        end

        IFG: begin
          if (ifg_q <= 8'd1) begin
            state_d = IDLE;
          end else begin
            ifg_d = ifg_q - 8'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ifg_q   <= 8'd0;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      bad_q   <= 1'b0;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      start_q <= 1'b0;
      uf_q    <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ifg_q   <= ifg_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      bad_q   <= bad_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
      start_q <= start_d;
      uf_q    <= uf_d;
      done_q  <= done_d;
      len_q   <= len_d;
    end
  end

  assign gmii_txd           = txd_q;
  assign gmii_tx_en         = en_q;
  assign gmii_tx_er         = er_q;
  assign tx_start_packet    = start_q;
  assign tx_error_underflow = uf_q;
  assign tx_frame_done      = done_q;
  assign tx_frame_len       = len_q;

endmodule
`default_nettype wire

// File: tb/tb_taxi_eth_gmii_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_taxi_eth_gmii_frame_tx
//  Purpose  : Self-checking bench for taxi_eth_gmii_frame_tx. Instance 0 pads
//             to 64 bytes, instance 1 has padding disabled. Expected GMII
//             bytes and frame lengths are queued when a frame is driven and
//             consumed as the DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_taxi_eth_gmii_frame_tx;

  typedef struct packed {
    logic [7:0] d;
    logic       er;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clk_enable;
  logic [7:0]  cfg_ifg;
  logic        cfg_tx_enable;

  logic [7:0]  tdata  [2];
  logic        tvalid [2];
  logic        tready [2];
  logic        tlast  [2];
  logic        tuser  [2];

  logic [7:0]  txd    [2];
  logic        en     [2];
  logic        er     [2];
  logic        sp     [2];
  logic        uf     [2];
  logic        fd     [2];
  logic [15:0] fl     [2];

  taxi_eth_gmii_frame_tx #(
    .PADDING_EN   (1'b1),
    .MIN_FRAME_LEN(64),
    .CNT_W        (16)
  ) u_dut_pad (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_tx_tdata   (tdata[0]),
    .s_axis_tx_tvalid  (tvalid[0]),
    .s_axis_tx_tready  (tready[0]),
    .s_axis_tx_tlast   (tlast[0]),
    .s_axis_tx_tuser   (tuser[0]),
    .gmii_txd          (txd[0]),
    .gmii_tx_en        (en[0]),
    .gmii_tx_er        (er[0]),
    .clk_enable        (clk_enable),
    .cfg_ifg           (cfg_ifg),
    .cfg_tx_enable     (cfg_tx_enable),
    .tx_start_packet   (sp[0]),
    .tx_error_underflow(uf[0]),
    .tx_frame_len      (fl[0]),
    .tx_frame_done     (fd[0])
  );

  taxi_eth_gmii_frame_tx #(
    .PADDING_EN   (1'b0),
    .MIN_FRAME_LEN(64),
    .CNT_W        (16)
  ) u_dut_nopad (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_tx_tdata   (tdata[1]),
    .s_axis_tx_tvalid  (tvalid[1]),
    .s_axis_tx_tready  (tready[1]),
    .s_axis_tx_tlast   (tlast[1]),
    .s_axis_tx_tuser   (tuser[1]),
    .gmii_txd          (txd[1]),
    .gmii_tx_en        (en[1]),
    .gmii_tx_er        (er[1]),
    .clk_enable        (clk_enable),
    .cfg_ifg           (cfg_ifg),
    .cfg_tx_enable     (cfg_tx_enable),
    .tx_start_packet   (sp[1]),
    .tx_error_underflow(uf[1]),
    .tx_frame_len      (fl[1]),
    .tx_frame_done     (fd[1])
  );

  int          n_checks = 0;
  int          n_fail   = 0;

  exp_t        sb_q[$];
  logic [15:0] sb_len_q[$];
  logic [7:0]  pl[$];

  bit          ce_s;
  bit          ce_mode  = 0;
  bit          mon_off  = 0;
  int          exp_gap  = 0;
  int          gap_inst = 0;
  int          starts [2] = '{0, 0};
  int          dones  [2] = '{0, 0};
  int          ufs    [2] = '{0, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ce_s <= clk_enable;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference CRC: data bit folded into the feedback term.
  function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic e_er);
    exp_t e;
    e.d  = d;
    e.er = e_er;
    sb_q.push_back(e);
  endtask

  task automatic push_preamble();
    repeat (7) push_byte(8'h55, 1'b0);
    push_byte(8'hD5, 1'b0);
  endtask

  task automatic fill_pl(input int n, input logic [7:0] base);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(base + 8'(i));
  endtask

  task automatic push_model(input bit pad_en, input bit bad, input int uf_at);
    logic [31:0] crc;
    logic [31:0] fcs;
    int          n;
    push_preamble();
    crc = 32'hFFFFFFFF;
    n   = 0;
    if (uf_at > 0) begin
      for (int i = 0; i < uf_at; i++) push_byte(pl[i], 1'b0);
      push_byte(8'h00, 1'b1);
      return;
    end
    foreach (pl[i]) begin
      push_byte(pl[i], 1'b0);
      crc = ref_crc(crc, pl[i]);
      n++;
    end
    if (pad_en) begin
      while (n < 60) begin
        push_byte(8'h00, 1'b0);
        crc = ref_crc(crc, 8'h00);
        n++;
      end
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) push_byte(fcs[8*k +: 8], bad);
    sb_len_q.push_back(16'(n + 4));
  endtask

  task automatic handshake(input int inst);
    bit acc;
    int k;
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 20000) begin
      @(negedge clk);
      acc = tready[inst];
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) check("handshake_timeout", 32'd1, 32'd0);
  endtask

  task automatic drive_frame(input int inst, input bit bad, input int uf_at, input bit no_last);
    int n;
    n = pl.size();
    for (int i = 0; i < n; i++) begin
      if (uf_at > 0 && i == uf_at) begin
        tvalid[inst] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      tdata[inst]  = pl[i];
      tvalid[inst] = 1'b1;
      tlast[inst]  = !no_last && (i == n - 1);
      tuser[inst]  = bad && !no_last && (i == n - 1);
      handshake(inst);
    end
    if (!no_last) begin
      tvalid[inst] = 1'b0;
      tlast[inst]  = 1'b0;
      tuser[inst]  = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || sb_len_q.size() != 0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("scoreboard_drain", 32'(sb_q.size() + sb_len_q.size()), 32'd0);
    repeat (20) begin @(posedge clk); #1; end
  endtask

  // clk_enable generator: one enabled cycle in ten while ce_mode is set.
  initial begin : ce_gen
    int ce_phase;
    ce_phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ce_mode) begin
        ce_phase   = (ce_phase == 9) ? 0 : ce_phase + 1;
        clk_enable = (ce_phase == 0);
      end else begin
        clk_enable = 1'b1;
      end
    end
  end

  // Output monitor: samples after every enabled edge.
  initial begin : monitor
    exp_t        e;
    bit          prev_en [2];
    bit          seen    [2];
    int          gap_cnt [2];
    logic [9:0]  last_out;
    prev_en  = '{1'b0, 1'b0};
    seen     = '{1'b0, 1'b0};
    gap_cnt  = '{0, 0};
    last_out = '0;
    forever begin
      @(negedge clk);
      if (ce_s) begin
        for (int i = 0; i < 2; i++) begin
          if (en[i]) begin
            if (!prev_en[i] && seen[i] && exp_gap != 0 && gap_inst == i)
              check("ifg_gap", 32'(gap_cnt[i]), 32'(exp_gap));
            gap_cnt[i] = 0;
            seen[i]    = 1'b1;
            if (!mon_off) begin
              if (sb_q.size() == 0) begin
                check("unexpected_byte", 32'd1, 32'd0);
              end else begin
                e = sb_q.pop_front();
                check("gmii_txd", 32'(txd[i]), 32'(e.d));
                check("gmii_tx_er", 32'(er[i]), 32'(e.er));
              end
            end
          end else begin
            gap_cnt[i]++;
            check("idle_txd_er", {23'd0, er[i], txd[i]}, 32'd0);
          end
          prev_en[i] = en[i];
          if (sp[i]) starts[i]++;
          if (uf[i]) ufs[i]++;
          if (fd[i]) begin
            dones[i]++;
            if (!mon_off) begin
              if (sb_len_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
              else check("tx_frame_len", 32'(fl[i]), 32'(sb_len_q.pop_front()));
            end
          end
        end
        last_out = {txd[0], en[0], er[0]};
      end else if (ce_mode) begin
        check("hold_outputs", 32'({txd[0], en[0], er[0]}), 32'(last_out));
      end
    end
  end

  initial begin : main
    int s0;
    int d0;
    rst_n         = 1'b0;
    clk_enable    = 1'b1;
    cfg_ifg       = 8'd12;
    cfg_tx_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tdata[i]  = 8'h00;
      tvalid[i] = 1'b0;
      tlast[i]  = 1'b0;
      tuser[i]  = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd[0]), 32'd0);
    check("rst_en_er", {30'd0, en[0], er[0]}, 32'd0);
    check("rst_tready", {30'd0, tready[0], tready[1]}, 32'd0);
    check("rst_status", {29'd0, sp[0], uf[0], fd[0]}, 32'd0);
    check("rst_frame_len", 32'(fl[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // No padding, "123456789", reference FCS, two frames back to back.
    fill_pl(9, 8'h31);
    for (int f = 0; f < 2; f++) begin
      push_preamble();
      for (int i = 0; i < 9; i++) push_byte(8'h31 + 8'(i), 1'b0);
      push_byte(8'h26, 1'b0);
      push_byte(8'h39, 1'b0);
      push_byte(8'hF4, 1'b0);
      push_byte(8'hCB, 1'b0);
      sb_len_q.push_back(16'd13);
    end
    gap_inst = 1;
    drive_frame(1, 1'b0, 0, 1'b0);
    exp_gap = 12;
    drive_frame(1, 1'b0, 0, 1'b0);
    wait_drain(2000);
    exp_gap = 0;

    // Padding: 10-byte payload 01..0A becomes a 64-byte frame.
    fill_pl(10, 8'h01);
    push_model(1'b1, 1'b0, 0);
    drive_frame(0, 1'b0, 0, 1'b0);
    wait_drain(2000);

    // cfg_tx_enable low blocks the start of a pending frame.
    s0 = starts[0];
    cfg_tx_enable = 1'b0;
    fill_pl(5, 8'hA0);
    push_model(1'b1, 1'b0, 0);
    fork
      drive_frame(0, 1'b0, 0, 1'b0);
      begin
        repeat (20) begin
          @(negedge clk);
          check("tready_blocked", 32'(tready[0]), 32'd0);
        end
        check("start_blocked", 32'(starts[0]), 32'(s0));
        @(posedge clk);
        #1;
        cfg_tx_enable = 1'b1;
      end
    join
    wait_drain(2000);

    // Underflow after byte 20 of 100, then a clean bad 60-byte frame.
    d0 = dones[0];
    fill_pl(100, 8'h10);
    push_model(1'b1, 1'b0, 20);
    drive_frame(0, 1'b0, 20, 1'b0);
    wait_drain(2000);
    check("underflow_pulses", 32'(ufs[0]), 32'd1);
    check("underflow_no_done", 32'(dones[0]), 32'(d0));
    fill_pl(60, 8'hC0);
    push_model(1'b1, 1'b1, 0);
    drive_frame(0, 1'b1, 0, 1'b0);
    wait_drain(2000);

    // cfg_ifg=0 behaves as a one-byte gap.
    cfg_ifg  = 8'd0;
    gap_inst = 0;
    fill_pl(70, 8'h40);
    push_model(1'b1, 1'b0, 0);
    push_model(1'b1, 1'b0, 0);
    drive_frame(0, 1'b0, 0, 1'b0);
    exp_gap = 1;
    drive_frame(0, 1'b0, 0, 1'b0);
    wait_drain(2000);
    exp_gap = 0;
    cfg_ifg = 8'd12;

    // clk_enable active one cycle in ten.
    ce_mode = 1'b1;
    fill_pl(60, 8'h80);
    push_model(1'b1, 1'b0, 0);
    drive_frame(0, 1'b0, 0, 1'b0);
    wait_drain(5000);
    ce_mode = 1'b0;
    repeat (20) begin @(posedge clk); #1; end

    // Reset in the middle of the payload.
    mon_off = 1'b1;
    fill_pl(30, 8'h20);
    drive_frame(0, 1'b0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd[0]), 32'd0);
    check("midrst_en_er", {30'd0, en[0], er[0]}, 32'd0);
    tvalid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_off = 1'b0;
    fill_pl(10, 8'h55);
    push_model(1'b1, 1'b0, 0);
    drive_frame(0, 1'b0, 0, 1'b0);
    wait_drain(2000);

    check("pad_start_pulses", 32'(starts[0]), 32'd9);
    check("pad_done_pulses", 32'(dones[0]), 32'd7);
    check("pad_underflow_total", 32'(ufs[0]), 32'd1);
    check("nopad_start_pulses", 32'(starts[1]), 32'd2);
    check("nopad_done_pulses", 32'(dones[1]), 32'd2);
    check("nopad_underflow_total", 32'(ufs[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
